// File: rtl/quiz_round_ctrl_if.sv
// Bus between the quiz sequencer and its surroundings: the button/answer path, the question DB
// and the 7-segment display decoders. The sequencer takes the slave side.
interface quiz_round_ctrl_if;
  logic        start;      // one-cycle pulse, begins a game
  logic        submit;     // one-cycle pulse, player commits answer
  logic [23:0] ans;        // BCD: [23:12] factor X, [11:0] factor Y
  logic [23:0] question;   // BCD: [23:12] factor A, [11:0] factor B
  logic [3:0]  num;        // question index to DB
  logic [3:0]  state;      // current state code
  logic [3:0]  score;      // correct answers this game
  logic [6:0]  time_left;  // seconds remaining, binary
  logic        correct;    // last judged answer correct
  logic        timeout;    // last question expired unanswered
  logic        done;       // game finished

  modport master (
    output start, submit, ans, question,
    input  num, state, score, time_left, correct, timeout, done
  );

  modport slave (
    input  start, submit, ans, question,
    output num, state, score, time_left, correct, timeout, done
  );
endinterface

// File: rtl/quiz_round_ctrl.sv
// Sequencer for one factorization quiz game: selects the DB question index, waits for the DB
// read, runs the per-question countdown, judges the submitted factor pair, keeps the score and
// steps through NumQ questions.
// Optional build macro QUIZ_SHUFFLE_EN: start the game at a pseudo-random question offset taken
// from a free-running mod-NumQ counter; every question is still visited exactly once.
module quiz_round_ctrl #(
  parameter int unsigned NumQ      = 8,          // questions per game (1..15)
  parameter int unsigned DbLat     = 1,          // cycles from NUM change to valid QUESTION (1..7)
  parameter int unsigned TickDiv   = 50000000,   // clock cycles per countdown second (>=2)
  parameter int unsigned TimeLimit = 30,         // seconds allowed per question (1..99)
  parameter int unsigned ResultCyc = 100000000   // cycles the judge result is held (>=1)
) (
  input logic              clk_i,
  input logic              rst_ni,
  quiz_round_ctrl_if.slave bus
);

  // State codes are visible on the STATE output, so they are fixed values.
  localparam logic [3:0] StIdle   = 4'd0;
  localparam logic [3:0] StLoad   = 4'd1;
  localparam logic [3:0] StAnswer = 4'd2;
  localparam logic [3:0] StJudge  = 4'd3;
  localparam logic [3:0] StResult = 4'd4;
  localparam logic [3:0] StFin    = 4'd5;

  localparam int unsigned IdxW  = (NumQ > 1) ? $clog2(NumQ) : 1;
  localparam int unsigned WaitW = (DbLat > 1) ? $clog2(DbLat) : 1;
  localparam int unsigned TickW = (TickDiv > 1) ? $clog2(TickDiv) : 1;
  localparam int unsigned ResW  = (ResultCyc > 1) ? $clog2(ResultCyc) : 1;

  localparam logic [IdxW-1:0]  LastIdx  = IdxW'(NumQ - 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(DbLat - 1);
  localparam logic [TickW-1:0] TickLast = TickW'(TickDiv - 1);
  localparam logic [ResW-1:0]  ResLast  = ResW'(ResultCyc - 1);
  localparam logic [6:0]       TimeInit = 7'(TimeLimit);

  logic [3:0]       state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [IdxW-1:0]  num_q, num_d;
  logic [3:0]       score_q, score_d;
  logic [6:0]       tl_q, tl_d;
  logic             correct_q, correct_d;
  logic             timeout_q, timeout_d;
  logic             done_q, done_d;
  logic [23:0]      q_q, q_d;
  logic [23:0]      a_q, a_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [TickW-1:0] tick_q, tick_d;
  logic [ResW-1:0]  res_q, res_d;

  logic             start_game;
  logic             tick_wrap;
  logic             answer_ok;
  logic             load_entry;
  logic [IdxW-1:0]  num_calc;

  // Factor order is free: the pair matches straight or crossed.
  assign answer_ok = ((a_q[23:12] == q_q[23:12]) && (a_q[11:0] == q_q[11:0])) ||
                     ((a_q[23:12] == q_q[11:0])  && (a_q[11:0] == q_q[23:12]));

  // Game sequencing, countdown, judging and scoring.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    score_d    = score_q;
    tl_d       = tl_q;
    correct_d  = correct_q;
    timeout_d  = timeout_q;
    done_d     = done_q;
    q_d        = q_q;
    a_d        = a_q;
    wait_d     = wait_q;
    tick_d     = tick_q;
    res_d      = res_q;
    start_game = 1'b0;
    tick_wrap  = 1'b0;

    case (state_q)
      StIdle, StFin: begin
        if (bus.start) begin
          start_game = 1'b1;
          state_d    = StLoad;
          idx_d      = '0;
          score_d    = '0;
          done_d     = 1'b0;
          correct_d  = 1'b0;
          timeout_d  = 1'b0;
          wait_d     = '0;
        end
      end

      StLoad: begin
        if (wait_q == WaitLast) begin
          q_d     = bus.question;
          tl_d    = TimeInit;
          tick_d  = '0;
          state_d = StAnswer;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end

      StAnswer: begin
        tick_wrap = (tick_q == TickLast);
        tick_d    = tick_wrap ? '0 : tick_q + TickW'(1);
        // The second still elapses on a submit cycle; only the expiry action is pre-empted.
        if (tick_wrap && (tl_q != 7'd0)) begin
          tl_d = tl_q - 7'd1;
        end
        if (bus.submit) begin
          a_d     = bus.ans;
          state_d = StJudge;
        end else if (tick_wrap && (tl_q == 7'd1)) begin
          timeout_d = 1'b1;
          correct_d = 1'b0;
          res_d     = '0;
          state_d   = StResult;
        end
      end

      StJudge: begin
        correct_d = answer_ok;
        if (answer_ok && (score_q != 4'hf)) begin
          score_d = score_q + 4'd1;
        end
        res_d   = '0;
        state_d = StResult;
      end

      StResult: begin
        if (res_q == ResLast) begin
          correct_d = 1'b0;
          timeout_d = 1'b0;
          if (idx_q == LastIdx) begin
            done_d  = 1'b1;
            state_d = StFin;
          end else begin
            idx_d   = idx_q + IdxW'(1);
            wait_d  = '0;
            state_d = StLoad;
          end
        end else begin
          res_d = res_q + ResW'(1);
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // NUM only moves on the edge that enters LOAD, so the DB address is stable for the whole read.
  assign load_entry = (state_q != StLoad) && (state_d == StLoad);

`ifdef QUIZ_SHUFFLE_EN
  logic [IdxW-1:0] free_q, free_d;
  logic [IdxW-1:0] off_q, off_d;
  logic [IdxW:0]   num_sum;
  logic [IdxW:0]   num_wrap;

  localparam logic [IdxW:0] NumQSum = (IdxW + 1)'(NumQ);

  // Free-running mod-NumQ counter; its value at START becomes the game's offset.
  always_comb begin
    free_d   = (free_q == LastIdx) ? '0 : free_q + IdxW'(1);
    off_d    = start_game ? free_q : off_q;
    // Both operands are below NumQ, so one conditional subtract is a full modulo.
    num_sum  = {1'b0, off_d} + {1'b0, idx_d};
    num_wrap = num_sum - NumQSum;
    num_calc = (num_sum >= NumQSum) ? num_wrap[IdxW-1:0] : num_sum[IdxW-1:0];
  end

  // Offset state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      free_q <= '0;
      off_q  <= '0;
    end else begin
      free_q <= free_d;
      off_q  <= off_d;
    end
  end
`else
  assign num_calc = idx_d;
`endif

  // Question index register next state.
  always_comb begin
    num_d = load_entry ? num_calc : num_q;
  end

  // Main state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      num_q     <= '0;
      score_q   <= '0;
      tl_q      <= '0;
      correct_q <= 1'b0;
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
      q_q       <= '0;
      a_q       <= '0;
      wait_q    <= '0;
      tick_q    <= '0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      num_q     <= num_d;
      score_q   <= score_d;
      tl_q      <= tl_d;
      correct_q <= correct_d;
      timeout_q <= timeout_d;
      done_q    <= done_d;
      q_q       <= q_d;
      a_q       <= a_d;
      wait_q    <= wait_d;
      tick_q    <= tick_d;
      res_q     <= res_d;
    end
  end

  assign bus.num       = 4'(num_q);
  assign bus.state     = state_q;
  assign bus.score     = score_q;
  assign bus.time_left = tl_q;
  assign bus.correct   = correct_q;
  assign bus.timeout   = timeout_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// Bench for quiz_round_ctrl: directed scenarios with literal expectations, then random play,
// all checked every cycle against a behavioural model of the game rules.
module tb_quiz_round_ctrl;
  localparam int NUM_Q      = 3;
  localparam int DB_LAT     = 1;
  localparam int TICK_DIV   = 4;
  localparam int TIME_LIMIT = 3;
  localparam int RESULT_CYC = 2;

  logic clk;
  logic rst_n;
  logic en;
  int   total;
  int   bad;

  logic [23:0] qtab [NUM_Q];

  quiz_round_ctrl_if bus_if ();

  quiz_round_ctrl #(
    .NumQ      (NUM_Q),
    .DbLat     (DB_LAT),
    .TickDiv   (TICK_DIV),
    .TimeLimit (TIME_LIMIT),
    .ResultCyc (RESULT_CYC)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int          m_state, m_num, m_score, m_tl, m_idx, m_off, m_el, m_left, m_cyc;
  bit          m_cor, m_to, m_done;
  logic [23:0] m_q, m_a;

  // Toy DB: question for the index currently selected (zero extra latency beyond DB_LAT=1).
  always_comb bus_if.question = qtab[m_num];

  function automatic bit pair_ok(logic [23:0] q, logic [23:0] a);
    logic [11:0] qlo, qhi, alo, ahi;
    qlo = (q[23:12] < q[11:0]) ? q[23:12] : q[11:0];
    qhi = (q[23:12] < q[11:0]) ? q[11:0]  : q[23:12];
    alo = (a[23:12] < a[11:0]) ? a[23:12] : a[11:0];
    ahi = (a[23:12] < a[11:0]) ? a[11:0]  : a[23:12];
    return (qlo == alo) && (qhi == ahi);
  endfunction

  function automatic int start_off(int cyc);
`ifdef QUIZ_SHUFFLE_EN
    return cyc % NUM_Q;
`else
    return 0;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state <= 0; m_num <= 0; m_score <= 0; m_tl <= 0; m_idx <= 0; m_off <= 0;
      m_el <= 0; m_left <= 0; m_cyc <= 0; m_cor <= 0; m_to <= 0; m_done <= 0;
      m_q <= '0; m_a <= '0;
    end else begin
      m_cyc <= m_cyc + 1;
      case (m_state)
        0, 5: if (bus_if.start) begin
          m_state <= 1; m_idx <= 0; m_score <= 0; m_done <= 0; m_cor <= 0; m_to <= 0;
          m_off <= start_off(m_cyc); m_num <= start_off(m_cyc); m_left <= DB_LAT;
        end
        1: if (m_left == 1) begin
          m_q <= bus_if.question; m_tl <= TIME_LIMIT; m_el <= 0; m_state <= 2;
        end else m_left <= m_left - 1;
        2: begin
          if (bus_if.submit) begin
            m_a <= bus_if.ans; m_state <= 3; m_tl <= TIME_LIMIT - (m_el + 1) / TICK_DIV;
          end else if (m_el + 1 == TIME_LIMIT * TICK_DIV) begin
            m_tl <= 0; m_to <= 1; m_cor <= 0; m_state <= 4; m_left <= RESULT_CYC;
          end else begin
            m_tl <= TIME_LIMIT - (m_el + 1) / TICK_DIV; m_el <= m_el + 1;
          end
        end
        3: begin
          m_cor <= pair_ok(m_q, m_a);
          if (pair_ok(m_q, m_a)) m_score <= (m_score < 15) ? m_score + 1 : 15;
          m_state <= 4; m_left <= RESULT_CYC;
        end
        4: if (m_left == 1) begin
          m_cor <= 0; m_to <= 0;
          if (m_idx == NUM_Q - 1) begin
            m_state <= 5; m_done <= 1;
          end else begin
            m_idx <= m_idx + 1; m_num <= (m_off + m_idx + 1) % NUM_Q;
            m_state <= 1; m_left <= DB_LAT;
          end
        end else m_left <= m_left - 1;
        default: m_state <= 0;
      endcase
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (en) begin
      chk("state", 32'(bus_if.state), 32'(m_state));
      chk("num", 32'(bus_if.num), 32'(m_num));
      chk("score", 32'(bus_if.score), 32'(m_score));
      chk("time_left", 32'(bus_if.time_left), 32'(m_tl));
      chk("correct", 32'(bus_if.correct), 32'(m_cor));
      chk("timeout", 32'(bus_if.timeout), 32'(m_to));
      chk("done", 32'(bus_if.done), 32'(m_done));
    end
  end

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [23:0] qv;
    total = 0; bad = 0; en = 1'b0;
    rst_n = 1'b1;
    bus_if.start = 1'b0; bus_if.submit = 1'b0; bus_if.ans = '0;
    for (int i = 0; i < NUM_Q; i++) qtab[i] = 24'h013017;
    #2 rst_n = 1'b0;
    en = 1'b1;
    step(2);
    chk("reset state", 32'(bus_if.state), 0);
    chk("reset time_left", 32'(bus_if.time_left), 0);
    chk("reset done", 32'(bus_if.done), 0);
    rst_n = 1'b1;
    step(1);

    // Scenario 1: correct answer with swapped factors.
    bus_if.start = 1'b1; step(1); bus_if.start = 1'b0;
    chk("s1 load", 32'(bus_if.state), 1);
    step(1);
    chk("s1 answer", 32'(bus_if.state), 2);
    chk("s1 tl", 32'(bus_if.time_left), 3);
    chk("s1 model tl", 32'(m_tl), 3);
`ifndef QUIZ_SHUFFLE_EN
    chk("s1 num0", 32'(bus_if.num), 0);
`endif
    bus_if.ans = 24'h017013; bus_if.submit = 1'b1; step(1); bus_if.submit = 1'b0;
    chk("s1 judge", 32'(bus_if.state), 3);
    step(1);
    chk("s1 result", 32'(bus_if.state), 4);
    chk("s1 correct", 32'(bus_if.correct), 1);
    chk("s1 score", 32'(bus_if.score), 1);
    chk("s1 model score", 32'(m_score), 1);
    step(2);
    chk("s1 next load", 32'(bus_if.state), 1);
`ifndef QUIZ_SHUFFLE_EN
    chk("s1 num1", 32'(bus_if.num), 1);
`endif

    // Scenario 2: countdown expiry.
    step(1);
    chk("s2 tl3", 32'(bus_if.time_left), 3);
    step(3);
    chk("s2 tl still 3", 32'(bus_if.time_left), 3);
    step(1);
    chk("s2 tl2", 32'(bus_if.time_left), 2);
    step(4);
    chk("s2 tl1", 32'(bus_if.time_left), 1);
    step(4);
    chk("s2 tl0", 32'(bus_if.time_left), 0);
    chk("s2 result", 32'(bus_if.state), 4);
    chk("s2 timeout", 32'(bus_if.timeout), 1);
    chk("s2 score kept", 32'(bus_if.score), 1);
    step(3);

    // Scenario 3: wrong answer, last question.
    chk("s3 answer", 32'(bus_if.state), 2);
    bus_if.ans = 24'h013018; bus_if.submit = 1'b1; step(1); bus_if.submit = 1'b0;
    step(1);
    chk("s3 correct", 32'(bus_if.correct), 0);
    chk("s3 score", 32'(bus_if.score), 1);
    step(2);
    chk("s3 fin", 32'(bus_if.state), 5);
    chk("s3 done", 32'(bus_if.done), 1);

    // Scenario 4: full game all correct.
    bus_if.start = 1'b1; step(1); bus_if.start = 1'b0;
    for (int i = 0; i < NUM_Q; i++) begin
      step(1);
      bus_if.ans = 24'h013017; bus_if.submit = 1'b1; step(1); bus_if.submit = 1'b0;
      step(1);
      chk("s4 score step", 32'(bus_if.score), 32'(i + 1));
      step(2);
    end
    chk("s4 fin", 32'(bus_if.state), 5);
    chk("s4 done", 32'(bus_if.done), 1);
    chk("s4 score3", 32'(bus_if.score), 3);
    bus_if.submit = 1'b1; step(1); bus_if.submit = 1'b0;
    chk("s4 fin hold", 32'(bus_if.state), 5);
    chk("s4 score hold", 32'(bus_if.score), 3);
    bus_if.start = 1'b1; step(1); bus_if.start = 1'b0;
    chk("s4 restart score", 32'(bus_if.score), 0);
    chk("s4 restart done", 32'(bus_if.done), 0);
`ifndef QUIZ_SHUFFLE_EN
    chk("s4 restart num", 32'(bus_if.num), 0);
`endif

    // Scenario 5: submit on the expiring cycle, then async reset mid-answer.
    step(1);
    step(11);
    chk("s5 tl1", 32'(bus_if.time_left), 1);
    bus_if.ans = 24'h017013; bus_if.submit = 1'b1; step(1); bus_if.submit = 1'b0;
    chk("s5 judge", 32'(bus_if.state), 3);
    chk("s5 tl0", 32'(bus_if.time_left), 0);
    chk("s5 no timeout", 32'(bus_if.timeout), 0);
    step(4);
    chk("s5 answer again", 32'(bus_if.state), 2);
    @(posedge clk); #2 rst_n = 1'b0; #1;
    chk("s5 async state", 32'(bus_if.state), 0);
    chk("s5 async score", 32'(bus_if.score), 0);
    chk("s5 async tl", 32'(bus_if.time_left), 0);
    chk("s5 async num", 32'(bus_if.num), 0);
    chk("s5 async correct", 32'(bus_if.correct), 0);
    step(1);
    rst_n = 1'b1;

    // Random play against the model.
    for (int i = 0; i < NUM_Q; i++) qtab[i] = 24'($urandom);
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 599) != 0);
      bus_if.start  = ($urandom_range(0, 15) == 0);
      bus_if.submit = ($urandom_range(0, 6) == 0);
      qv = qtab[m_num];
      case ($urandom_range(0, 3))
        0: bus_if.ans = qv;
        1: bus_if.ans = {qv[11:0], qv[23:12]};
        2: bus_if.ans = 24'($urandom);
        default: bus_if.ans = qv ^ (24'd1 << $urandom_range(0, 23));
      endcase
      if (c % 700 == 699) for (int i = 0; i < NUM_Q; i++) qtab[i] = 24'($urandom);
    end
    @(negedge clk);
    rst_n = 1'b1; bus_if.start = 1'b0; bus_if.submit = 1'b0;
    step(2);
    en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
